// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared Y86-64 SEQ sequencer types, codes and helpers
package seq_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_PCUPD,
        ST_HALT
    } state_t;

    // Instructions that read or write data memory in the Memory stage
    function automatic logic needs_mem(input logic [3:0] ic);
        case (ic)
            I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: needs_mem = 1'b1;
            I_HALT, I_NOP, I_RRMOVQ, I_IRMOVQ, I_OPQ, I_JXX:    needs_mem = 1'b0;
            default:                                            needs_mem = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_stage_controller_if.sv
// rtl/seq_stage_controller_if.sv - data-memory request/acknowledge handshake
interface seq_stage_controller_if;
    logic mem_req;
    logic mem_ack;
    logic dmem_error;

    modport master (output mem_req, input mem_ack, input dmem_error);
    modport slave  (input mem_req, output mem_ack, output dmem_error);
endinterface

// File: rtl/seq_sat_counter.sv
// rtl/seq_sat_counter.sv - saturating up-counter with enable and synchronous clear
module seq_sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] q
);

    // Count up on enable, stick at all-ones
    always_ff @(posedge clk) begin
        if (rst || clr)
            q <= '0;
        else if (en && (q != '1))
            q <= q + 1'b1;
    end

endmodule

// File: rtl/seq_stage_controller.sv
// rtl/seq_stage_controller.sv - SEQ stage sequencer; optional SEQ_CTRL_SINGLE_STEP_EN parks in IDLE after each instruction
module seq_stage_controller
    import seq_pkg::*;
#(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [3:0]             icode,
    input  logic                   instr_valid,
    input  logic                   imem_error,
    input  logic                   step,
    seq_stage_controller_if.master mem,
    output logic [5:0]             stage_en,
    output logic                   busy,
    output logic                   halted,
    output logic [1:0]             stat,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       instr_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t            state, state_nxt;
    logic [1:0]        stat_nxt;
    logic [3:0]        icode_q;
    logic              latch_icode;
    logic              retire;
    logic              mem_active;
    logic              timeout;
    logic              go;
    logic [WAIT_W-1:0] wait_cnt;

`ifdef SEQ_CTRL_SINGLE_STEP_EN
    assign go = start | step;
`else
    logic unused_step;
    assign unused_step = step;
    assign go = start;
`endif

    assign mem_active  = (state == ST_MEMORY) && needs_mem(icode_q);
    assign mem.mem_req = mem_active;
    // The ack-wins rule is handled by testing mem_ack before timeout below
    assign timeout     = mem_active && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    assign busy        = (state != ST_IDLE) && (state != ST_HALT);
    assign halted      = (state == ST_HALT);

    // Next-state, status and retire decisions
    always_comb begin
        state_nxt   = state;
        stat_nxt    = stat;
        latch_icode = 1'b0;
        retire      = 1'b0;
        case (state)
            ST_IDLE: if (go) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (imem_error) begin
                    state_nxt = ST_HALT;
                    stat_nxt  = STAT_ADR;
                end else if (icode == I_HALT) begin
                    state_nxt = ST_HALT;
                    stat_nxt  = STAT_HLT;
                    retire    = 1'b1;
                end else if (!instr_valid) begin
                    state_nxt = ST_HALT;
                    stat_nxt  = STAT_INS;
                end else begin
                    latch_icode = 1'b1;
                    state_nxt   = ST_DECODE;
                end
            end
            ST_DECODE:  state_nxt = ST_EXECUTE;
            ST_EXECUTE: state_nxt = ST_MEMORY;
            ST_MEMORY: begin
                if (!mem_active) begin
                    state_nxt = ST_WRITEBACK;
                end else if (mem.mem_ack) begin
                    if (mem.dmem_error) begin
                        state_nxt = ST_HALT;
                        stat_nxt  = STAT_ADR;
                    end else begin
                        state_nxt = ST_WRITEBACK;
                    end
                end else if (timeout) begin
                    state_nxt = ST_HALT;
                    stat_nxt  = STAT_ADR;
                end
            end
            ST_WRITEBACK: state_nxt = ST_PCUPD;
            ST_PCUPD: begin
                retire = 1'b1;
`ifdef SEQ_CTRL_SINGLE_STEP_EN
                state_nxt = ST_IDLE;
`else
                state_nxt = ST_FETCH;
`endif
            end
            ST_HALT: state_nxt = ST_HALT;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, status and latched instruction code
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            stat    <= STAT_AOK;
            icode_q <= 4'h0;
        end else begin
            state <= state_nxt;
            stat  <= stat_nxt;
            if (latch_icode)
                icode_q <= icode;
        end
    end

    // One-hot stage enable {P,W,M,E,D,F} decoded from the state register
    always_comb begin
        stage_en = 6'b000000;
        case (state)
            ST_FETCH:     stage_en = 6'b000001;
            ST_DECODE:    stage_en = 6'b000010;
            ST_EXECUTE:   stage_en = 6'b000100;
            ST_MEMORY:    stage_en = 6'b001000;
            ST_WRITEBACK: stage_en = 6'b010000;
            ST_PCUPD:     stage_en = 6'b100000;
            default:      stage_en = 6'b000000;
        endcase
    end

    seq_sat_counter #(.W(CNT_W)) u_cycle_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (busy),
        .q   (cycle_cnt)
    );

    seq_sat_counter #(.W(CNT_W)) u_instr_cnt (
        .clk (clk),
        .rst (rst),
        .clr (1'b0),
        .en  (retire),
        .q   (instr_cnt)
    );

    seq_sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!mem_active),
        .en  (mem_active && !mem.mem_ack),
        .q   (wait_cnt)
    );

endmodule

// File: tb/tb_seq_stage_controller.sv
// tb/tb_seq_stage_controller.sv - self-checking bench for seq_stage_controller
module tb_seq_stage_controller;

    logic        clk = 1'b0;
    logic        rst, start, instr_valid, imem_error, step;
    logic [3:0]  icode;
    logic [5:0]  stage_en;
    logic        busy, halted;
    logic [1:0]  stat;
    logic [31:0] cycle_cnt, instr_cnt;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef SEQ_CTRL_SINGLE_STEP_EN
    localparam logic [5:0] SE_AFTER_PC = 6'h00;
`else
    localparam logic [5:0] SE_AFTER_PC = 6'h01;
`endif

    seq_stage_controller_if mem_if ();

    seq_stage_controller #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .icode       (icode),
        .instr_valid (instr_valid),
        .imem_error  (imem_error),
        .step        (step),
        .mem         (mem_if.master),
        .stage_en    (stage_en),
        .busy        (busy),
        .halted      (halted),
        .stat        (stat),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] se;
        bit         req;
        logic [3:0] ic;
        bit         ack;
        bit         stp;
    } cyc_t;

    cyc_t plan[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; icode = 4'h0; instr_valid = 1'b0;
        imem_error = 1'b0; step = 1'b0;
        mem_if.mem_ack = 1'b0; mem_if.dmem_error = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic kick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic bit is_mem_instr(input logic [3:0] ic);
        return ic == 4'h4 || ic == 4'h5 || ic == 4'h8 || ic == 4'h9 || ic == 4'hA || ic == 4'hB;
    endfunction

    // Expected per-cycle stage trace of one legal, fault-free instruction
    function automatic void plan_instr(input logic [3:0] ic, input int dly);
        plan.push_back('{6'h01, 1'b0, ic, 1'b0, 1'b0});
        plan.push_back('{6'h02, 1'b0, 4'h0, 1'b0, 1'b0});
        plan.push_back('{6'h04, 1'b0, 4'h0, 1'b0, 1'b0});
        if (is_mem_instr(ic)) begin
            for (int k = 0; k <= dly; k++)
                plan.push_back('{6'h08, 1'b1, 4'h0, (k == dly), 1'b0});
        end else begin
            plan.push_back('{6'h08, 1'b0, 4'h0, 1'b0, 1'b0});
        end
        plan.push_back('{6'h10, 1'b0, 4'h0, 1'b0, 1'b0});
        plan.push_back('{6'h20, 1'b0, 4'h0, 1'b0, 1'b0});
`ifdef SEQ_CTRL_SINGLE_STEP_EN
        plan.push_back('{6'h00, 1'b0, 4'h0, 1'b0, 1'b1});
`endif
    endfunction

    task automatic test_reset();
        do_reset();
        n_cmp++; if (stage_en !== 6'h00) begin n_bad++; $display("FAIL reset_stage_en got=%h exp=00", stage_en); end
        n_cmp++; if (mem_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL reset_mem_req got=%b exp=0", mem_if.mem_req); end
        n_cmp++; if ({busy, halted} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_halted got=%b exp=00", {busy, halted}); end
        n_cmp++; if (stat !== 2'd0) begin n_bad++; $display("FAIL reset_stat got=%0d exp=0", stat); end
        n_cmp++; if ({cycle_cnt, instr_cnt} !== 64'd0) begin n_bad++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", cycle_cnt, instr_cnt); end
        repeat (3) tick();
        n_cmp++; if (stage_en !== 6'h00 || busy !== 1'b0) begin n_bad++; $display("FAIL idle_without_start got=%h/%b exp=00/0", stage_en, busy); end
    endtask

    task automatic test_straight();
        do_reset();
        kick();
        icode = 4'h6; instr_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (stage_en !== 6'(1 << k)) begin n_bad++; $display("FAIL straight_stage%0d got=%h exp=%h", k, stage_en, 6'(1 << k)); end
            n_cmp++; if (mem_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL straight_mem_req%0d got=%b exp=0", k, mem_if.mem_req); end
            tick();
        end
        n_cmp++; if (stage_en !== SE_AFTER_PC) begin n_bad++; $display("FAIL straight_return got=%h exp=%h", stage_en, SE_AFTER_PC); end
        n_cmp++; if (instr_cnt !== 32'd1) begin n_bad++; $display("FAIL straight_instr_cnt got=%0d exp=1", instr_cnt); end
        n_cmp++; if (cycle_cnt !== 32'd6) begin n_bad++; $display("FAIL straight_cycle_cnt got=%0d exp=6", cycle_cnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        kick();
        icode = 4'h5; instr_valid = 1'b1;
        repeat (3) tick();
        icode = 4'h1;
        for (int k = 0; k < 4; k++) begin
            mem_if.mem_ack = (k == 3);
            n_cmp++; if (stage_en !== 6'h08 || mem_if.mem_req !== 1'b1) begin n_bad++; $display("FAIL memwait_cycle%0d got=%h/%b exp=08/1", k, stage_en, mem_if.mem_req); end
            tick();
        end
        mem_if.mem_ack = 1'b0;
        n_cmp++; if (stage_en !== 6'h10 || mem_if.mem_req !== 1'b0) begin n_bad++; $display("FAIL memwait_writeback got=%h/%b exp=10/0", stage_en, mem_if.mem_req); end
        tick();
        tick();
        n_cmp++; if (cycle_cnt !== 32'd9) begin n_bad++; $display("FAIL memwait_cycle_cnt got=%0d exp=9", cycle_cnt); end
        n_cmp++; if (stage_en !== SE_AFTER_PC) begin n_bad++; $display("FAIL memwait_return got=%h exp=%h", stage_en, SE_AFTER_PC); end
    endtask

    task automatic test_faults();
        logic [3:0] f_ic[3]   = '{4'h0, 4'hC, 4'h6};
        logic       f_val[3]  = '{1'b1, 1'b0, 1'b1};
        logic       f_imem[3] = '{1'b0, 1'b0, 1'b1};
        logic [1:0] f_stat[3] = '{2'd1, 2'd3, 2'd2};
        int         f_ret[3]  = '{1, 0, 0};
        for (int i = 0; i < 3; i++) begin
            do_reset();
            kick();
            icode = f_ic[i]; instr_valid = f_val[i]; imem_error = f_imem[i];
            tick();
            imem_error = 1'b0;
            n_cmp++; if (halted !== 1'b1 || busy !== 1'b0 || stage_en !== 6'h00) begin n_bad++; $display("FAIL fault%0d_halt got=%b/%b/%h exp=1/0/00", i, halted, busy, stage_en); end
            n_cmp++; if (stat !== f_stat[i]) begin n_bad++; $display("FAIL fault%0d_stat got=%0d exp=%0d", i, stat, f_stat[i]); end
            n_cmp++; if (instr_cnt !== 32'(f_ret[i])) begin n_bad++; $display("FAIL fault%0d_instr_cnt got=%0d exp=%0d", i, instr_cnt, f_ret[i]); end
        end
        for (int k = 0; k < 20; k++) begin
            start = k[0];
            step = k[1];
            icode = 4'h6; instr_valid = 1'b1;
            tick();
            n_cmp++; if (halted !== 1'b1 || stat !== 2'd2) begin n_bad++; $display("FAIL halt_sticky%0d got=%b/%0d exp=1/2", k, halted, stat); end
        end
        start = 1'b0; step = 1'b0;
    endtask

    task automatic test_mem_fault();
        do_reset();
        kick();
        icode = 4'hA; instr_valid = 1'b1;
        repeat (3) tick();
        mem_if.mem_ack = 1'b1; mem_if.dmem_error = 1'b1;
        tick();
        mem_if.mem_ack = 1'b0; mem_if.dmem_error = 1'b0;
        n_cmp++; if (stage_en !== 6'h00 || halted !== 1'b1) begin n_bad++; $display("FAIL dmem_error_halt got=%h/%b exp=00/1", stage_en, halted); end
        n_cmp++; if (stat !== 2'd2 || instr_cnt !== 32'd0) begin n_bad++; $display("FAIL dmem_error_stat got=%0d/%0d exp=2/0", stat, instr_cnt); end

        do_reset();
        kick();
        icode = 4'h4; instr_valid = 1'b1;
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            n_cmp++; if (stage_en !== 6'h08 || mem_if.mem_req !== 1'b1) begin n_bad++; $display("FAIL timeout_wait%0d got=%h/%b exp=08/1", k, stage_en, mem_if.mem_req); end
            tick();
        end
        n_cmp++; if (halted !== 1'b1 || stat !== 2'd2) begin n_bad++; $display("FAIL timeout_halt got=%b/%0d exp=1/2", halted, stat); end
    endtask

    task automatic test_reset_mid_mem();
        do_reset();
        kick();
        icode = 4'h9; instr_valid = 1'b1;
        repeat (4) tick();
        n_cmp++; if (mem_if.mem_req !== 1'b1) begin n_bad++; $display("FAIL midmem_req got=%b exp=1", mem_if.mem_req); end
        rst = 1'b1;
        mem_if.mem_ack = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({stage_en, mem_if.mem_req, busy, halted, stat} !== 11'd0 || {cycle_cnt, instr_cnt} !== 64'd0) begin
            n_bad++; $display("FAIL midmem_reset got=%h/%b/%b/%b/%0d/%0d/%0d exp=all zero", stage_en, mem_if.mem_req, busy, halted, stat, cycle_cnt, instr_cnt);
        end
        repeat (3) tick();
        mem_if.mem_ack = 1'b0;
        n_cmp++; if (stage_en !== 6'h00 || busy !== 1'b0 || stat !== 2'd0) begin n_bad++; $display("FAIL midmem_ack_ignored got=%h/%b/%0d exp=00/0/0", stage_en, busy, stat); end
    endtask

    task automatic test_back_to_back();
        int n_instr;
        int busy_cycles;
        do_reset();
        n_instr = 10;
        for (int i = 0; i < n_instr; i++)
            plan_instr(4'($urandom_range(1, 11)), $urandom_range(0, 3));
        kick();
        busy_cycles = 0;
        instr_valid = 1'b1;
        while (plan.size() > 0) begin
            cyc_t e;
            e = plan.pop_front();
            icode = (e.se == 6'h01) ? e.ic : 4'($urandom_range(0, 15));
            mem_if.mem_ack = e.ack;
            step = e.stp;
            n_cmp++; if (stage_en !== e.se) begin n_bad++; $display("FAIL b2b_stage got=%h exp=%h", stage_en, e.se); end
            n_cmp++; if (mem_if.mem_req !== e.req) begin n_bad++; $display("FAIL b2b_mem_req got=%b exp=%b", mem_if.mem_req, e.req); end
            if (e.se != 6'h00) busy_cycles++;
            tick();
        end
        mem_if.mem_ack = 1'b0; step = 1'b0; icode = 4'h1;
        n_cmp++; if (cycle_cnt !== 32'(busy_cycles)) begin n_bad++; $display("FAIL b2b_cycle_cnt got=%0d exp=%0d", cycle_cnt, busy_cycles); end
        n_cmp++; if (instr_cnt !== 32'(n_instr)) begin n_bad++; $display("FAIL b2b_instr_cnt got=%0d exp=%0d", instr_cnt, n_instr); end
        n_cmp++; if (stat !== 2'd0 || halted !== 1'b0) begin n_bad++; $display("FAIL b2b_stat got=%0d/%b exp=0/0", stat, halted); end
    endtask

`ifdef SEQ_CTRL_SINGLE_STEP_EN
    task automatic test_single_step();
        do_reset();
        kick();
        icode = 4'h1; instr_valid = 1'b1;
        repeat (6) tick();
        repeat (5) tick();
        n_cmp++; if (stage_en !== 6'h00 || busy !== 1'b0 || cycle_cnt !== 32'd6) begin n_bad++; $display("FAIL step_parked got=%h/%b/%0d exp=00/0/6", stage_en, busy, cycle_cnt); end
        step = 1'b1;
        tick();
        step = 1'b0;
        n_cmp++; if (stage_en !== 6'h01) begin n_bad++; $display("FAIL step_resume got=%h exp=01", stage_en); end
        repeat (6) tick();
        n_cmp++; if (instr_cnt !== 32'd2 || cycle_cnt !== 32'd12) begin n_bad++; $display("FAIL step_second got=%0d/%0d exp=2/12", instr_cnt, cycle_cnt); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_straight();
        test_mem_wait();
        test_faults();
        test_mem_fault();
        test_reset_mid_mem();
        test_back_to_back();
`ifdef SEQ_CTRL_SINGLE_STEP_EN
        test_single_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seq_stage_controller.md
Name: seq_stage_controller

Overview:
- Multi-cycle sequencer for the Y86-64 SEQ processor.
- Steps the datapath through Fetch, Decode, Execute, Memory, Writeback and PC-update, one stage enable at a time.
- Holds in Memory until the data-memory handshake completes.
- Produces the architectural status code and performance counters. Sits above the fetch/decode/execute/memory units and gates their clocked updates.

Parameters:
CNT_W, 32, width of cycle and instruction counters
MEM_TIMEOUT, 16, maximum cycles waiting for mem_ack before an address fault

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  reset; synchronous, active-high
start  in  1  pulse; leaves IDLE
icode  in  4  instruction code from fetch, valid during FETCH
instr_valid  in  1  fetch decoded a legal icode
imem_error  in  1  instruction-memory fault, valid during FETCH
mem_ack  in  1  data-memory transaction complete
dmem_error  in  1  data-memory fault, qualified by mem_ack
step  in  1  single-step advance (only with SEQ_CTRL_SINGLE_STEP_EN)
stage_en  out  6  one-hot {P,W,M,E,D,F}; bit0 = Fetch
mem_req  out  1  data-memory request, level held until ack
busy  out  1  high in any state except IDLE/HALT
halted  out  1  high in HALT
stat  out  2  0 AOK, 1 HLT, 2 ADR, 3 INS
cycle_cnt  out  CNT_W  busy cycles, saturating
instr_cnt  out  CNT_W  retired instructions, saturating

Behaviour:
- Reset (synchronous, wins over every other input): state IDLE, stage_en=0, mem_req=0, busy=0, halted=0, stat=AOK, counters=0, icode_q=0.
- States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT. stage_en is a registered one-hot of the current state; it is 0 in IDLE/HALT.
- IDLE: start=1 -> FETCH next cycle.
- FETCH, checked in this priority order:
  - imem_error -> HALT, stat=ADR.
  - icode==0 (halt) -> HALT, stat=HLT, instr_cnt+1.
  - !instr_valid -> HALT, stat=INS.
  - Otherwise latch icode_q -> DECODE.
- DECODE -> EXECUTE -> MEMORY, one cycle each.
- MEMORY:
  - If icode_q is in {4,5,8,9,A,B}: mem_req=1 from state entry. Remain in MEMORY until mem_ack.
    - mem_ack with dmem_error -> HALT, stat=ADR; WRITEBACK is skipped.
    - mem_ack without dmem_error -> WRITEBACK; mem_req drops the same edge.
  - Otherwise: one cycle, mem_req=0.
- Timeout: wait counter increments each MEMORY cycle without ack. Reaching MEM_TIMEOUT -> HALT, stat=ADR. An ack arriving on the same cycle as the timeout wins.
- WRITEBACK -> PCUPD. PCUPD -> FETCH, instr_cnt+1.
- Latency: non-memory instruction takes 6 cycles; memory instruction takes 6 + ack wait.
- HALT is sticky until rst. start is ignored outside IDLE.
- cycle_cnt increments on every cycle with busy=1. Both counters saturate at all-ones.
- mem_ack outside a MEMORY-with-request cycle is ignored.

Optional Feature:
SEQ_CTRL_SINGLE_STEP_EN
- Defined: PCUPD goes to IDLE instead of FETCH. The next instruction starts on step=1 (start also accepted). busy=0 while parked, so cycle_cnt pauses.
- Undefined: step port still exists but is ignored. Execution is continuous.

Decomposition:
- Shared package seq_pkg holds:
  - icode localparams (HALT=0 ... POPQ=B);
  - stat codes (AOK/HLT/ADR/INS);
  - state enum;
  - a needs_mem(icode) function, reused by the memory unit.
- One natural sub-module, seq_sat_counter (parameterised width, enable, synchronous clear), instantiated for cycle_cnt, instr_cnt and the memory wait counter.

Test Plan:
- Straight run: rst, start, icode=6 valid, no memory -> stage_en 01,02,04,08,10,20 over 6 cycles, then 01 again; instr_cnt=1, mem_req never high.
- Memory wait: icode=5, mem_ack 3 cycles after MEMORY entry -> mem_req high exactly 4 cycles, WRITEBACK follows, cycle_cnt=9 at return to FETCH.
- Faults:
  - icode=0 -> HALT, stat=1, instr_cnt+1.
  - icode=C with instr_valid=0 -> stat=3.
  - imem_error with icode=6 -> stat=2.
  - halted stays 1 for 20 cycles with start pulsed.
- Memory fault/timeout:
  - icode=A, mem_ack with dmem_error -> stat=2, no W enable.
  - No ack at MEM_TIMEOUT=4 -> HALT after 4 MEMORY cycles.
- Reset mid-MEMORY with mem_req=1 -> next cycle all outputs at reset values; mem_ack then ignored.
- Single-step (macro defined): two instructions require two step pulses; without a pulse, stays IDLE with cycle_cnt frozen.
